asteroid_field_ctrl: RTL and testbench
======================================

// Module: asteroid_field_ctrl
// PURPOSE
//  Owns position, motion, respawn and collision bookkeeping for N_OBJ falling
//  obstacles, replacing the hard-wired single asteroid and ad-hoc collision loop in
//  the game top. Per frame it steps every obstacle and re-seeds hit/off-screen
//  obstacles from an LFSR. It also accumulates per-pixel ship/obstacle overlap into
//  a per-obstacle hit mask and a saturating hit counter. Sits between display_480p
//  (frame pulse) and the sprite instances (drawing flags in, positions out).
// PARAMETERS
//  N_OBJ        10          number of obstacles (1..32)
//  SCREEN_CORDW 16          coordinate width
//  H_RES        640         visible width
//  V_RES        480         visible height
//  OBJ_W        40          obstacle width on screen (sprite WIDTH*SCALE)
//  DX           1           x step per frame, unsigned
//  DY           3           y step per frame, unsigned, >0
//  LFSR_SEED    16'hACE1    LFSR reset value, nonzero
//  HIT_CNTW     8           hit counter width
// PORTS
//  clk_pix      in   1                 pixel clock
//  rst          in   1                 async reset, active-high
//  en           in   1                 field enable (SW[9])
//  frame        in   1                 1-cycle pulse, start of frame
//  ship_drawing in   1                 ship sprite drawing current pixel
//  obj_drawing  in   N_OBJ             per-obstacle sprite drawing flags
//  obj_x        out  N_OBJ*SCREEN_CORDW packed x, obstacle i at [i*CORDW +: CORDW]
//  obj_y        out  N_OBJ*SCREEN_CORDW packed y, same packing
//  hit_mask     out  N_OBJ             obstacles overlapped by ship last frame
//  collision    out  1                 |hit_mask
//  hit_count    out  HIT_CNTW          saturating total of hits
//  busy         out  1                 high while in S_MOVE
// BEHAVIOUR
//  Reset (async): obj_x[i]=i*(H_RES/N_OBJ), obj_y[i]=0; hit_mask=0, collision=0,
//   hit_count=0, busy=0, acc=0, lfsr=LFSR_SEED, idx=0, state=S_SCAN.
//  LFSR: 16-bit Galois, mask 16'hB400; steps once per S_MOVE cycle only; never 0.
//  rnd_x = lfsr % (H_RES-OBJ_W) (constant-divisor remainder), width SCREEN_CORDW.
//  States:
//   S_SCAN: each cycle, if en: acc[i] <= acc[i] | (ship_drawing & obj_drawing[i]).
//    On frame: hit_mask<=acc, collision<=|acc, hit_count<=sat(hit_count+popcount(acc)),
//    acc<=0; frame in the same cycle as an overlap counts toward the closing frame.
//    Then -> S_MOVE (idx=0) if en, else stay in S_SCAN (positions frozen).
//   S_MOVE: one obstacle per cycle, idx 0..N_OBJ-1; busy=1; acc not updated.
//    If hit_mask[idx]: x<=rnd_x, y<=0 (respawn).
//    Else if y+DY >= V_RES: x<=rnd_x, y<=0.
//    Else: y<=y+DY; x<=(x+DX >= H_RES-OBJ_W) ? 0 : x+DX.
//    Arithmetic in SCREEN_CORDW+1 bits; no overflow wrap.
//    After idx=N_OBJ-1 -> S_SCAN, busy=0. Latency: all positions final
//    N_OBJ cycles after the frame pulse.
//  frame during S_MOVE: ignored (no commit, no restart); see S_SCAN for commit.
//  en deasserted mid-S_MOVE: current pass completes; no further passes until en.
//  en=0 in S_SCAN: no accumulation; frame still commits (hit_mask -> 0).
//  Reset mid-operation restores all reset values immediately.
//  hit_count saturates at all-ones and holds there.
// TESTING
//  1 Reset, en=1, no overlap, 1 frame -> obj_y[i]=3, obj_x[i]=i*64+1 after 10 cycles; busy 10 cycles.
//  2 ship & obj_drawing[2] high 5 cycles, frame -> hit_mask=0x004, collision=1,
//    hit_count=1; next pass obj 2 y=0, x=rnd_x<600.
//  3 Obj 0 at y=477, frame -> y=0, x=rnd_x; obj at x=599 -> x=0.
//  4 en=0 over 3 frames -> positions unchanged, hit_mask=0, overlaps ignored.
//  5 HIT_CNTW=2, overlap 3 objects on each of 2 frames -> hit_count=3, holds.
//  6 rst pulsed during S_MOVE at idx=4 -> all reset values same cycle, busy=0.

Source files
------------

// File: rtl/asteroid_field_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : asteroid_field_if                                                |
// | Brief    : Bundle between the game top and asteroid_field_ctrl: frame and   |
// |            drawing flags in; obstacle positions and hit status out.         |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface asteroid_field_if #(
  parameter int N_OBJ        = 10,
  parameter int SCREEN_CORDW = 16,
  parameter int HIT_CNTW     = 8
);
  logic                          en;
  logic                          frame;
  logic                          ship_drawing;
  logic [N_OBJ-1:0]              obj_drawing;
  logic [N_OBJ*SCREEN_CORDW-1:0] obj_x;
  logic [N_OBJ*SCREEN_CORDW-1:0] obj_y;
  logic [N_OBJ-1:0]              hit_mask;
  logic                          collision;
  logic [HIT_CNTW-1:0]           hit_count;
  logic                          busy;

  // Game top / testbench side
  modport master (
    output en, frame, ship_drawing, obj_drawing,
    input  obj_x, obj_y, hit_mask, collision, hit_count, busy
  );

  // Field controller side
  modport slave (
    input  en, frame, ship_drawing, obj_drawing,
    output obj_x, obj_y, hit_mask, collision, hit_count, busy
  );
endinterface
`default_nettype wire

// File: rtl/asteroid_field_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : asteroid_field_ctrl                                              |
// | Brief    : Steps N_OBJ falling obstacles once per frame, respawns hit or    |
// |            off-screen ones at an LFSR-derived x, and accumulates per-pixel  |
// |            ship/obstacle overlap into a hit mask and saturating counter.    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module asteroid_field_ctrl #(
  parameter int          N_OBJ        = 10,
  parameter int          SCREEN_CORDW = 16,
  parameter int          H_RES        = 640,
  parameter int          V_RES        = 480,
  parameter int          OBJ_W        = 40,
  parameter int          DX           = 1,
  parameter int          DY           = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          HIT_CNTW     = 8
) (
  input  wire logic       clk_pix,
  input  wire logic       rst,
  asteroid_field_if.slave bus
);

  localparam int c_IDXW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int c_W1   = SCREEN_CORDW + 1;
  // Wide enough for hit_count plus a popcount of up to 32 hits
  localparam int c_SUMW = ((HIT_CNTW > 6) ? HIT_CNTW : 6) + 1;

  localparam logic [c_W1-1:0]   c_VRES    = c_W1'(V_RES);
  localparam logic [c_W1-1:0]   c_XLIM    = c_W1'(H_RES - OBJ_W);
  localparam logic [15:0]       c_XMOD    = 16'(H_RES - OBJ_W);
  localparam logic [15:0]       c_LFSR_TAPS = 16'hB400;
  localparam logic [c_SUMW-1:0] c_CNT_MAX = {{(c_SUMW-HIT_CNTW){1'b0}}, {HIT_CNTW{1'b1}}};

  typedef enum logic [0:0] {
    S_SCAN = 1'b0,
    S_MOVE = 1'b1
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [c_IDXW-1:0]               r_idx;
  logic                            w_last;
  logic [N_OBJ-1:0]                r_acc;
  logic [N_OBJ-1:0]                w_acc_cur;
  logic [N_OBJ-1:0]                r_hit_mask;
  logic                            r_collision;
  logic [HIT_CNTW-1:0]             r_hit_count;
  logic [HIT_CNTW-1:0]             w_hit_count_nxt;
  logic [c_SUMW-1:0]               w_pop;
  logic [c_SUMW-1:0]               w_sum;
  logic [15:0]                     r_lfsr;
  logic [15:0]                     w_rnd_full;
  logic [SCREEN_CORDW-1:0]         w_rnd_x;
  logic [N_OBJ*SCREEN_CORDW-1:0]   w_obj_x;
  logic [N_OBJ*SCREEN_CORDW-1:0]   w_obj_y;

  assign w_last     = (r_idx == c_IDXW'(N_OBJ - 1));
  // Overlap seen this very cycle is folded in, so a frame pulse coinciding
  // with an overlap still credits it to the frame being closed.
  assign w_acc_cur  = bus.en ? (r_acc | ({N_OBJ{bus.ship_drawing}} & bus.obj_drawing))
                             : r_acc;
  assign w_rnd_full = r_lfsr % c_XMOD;
  assign w_rnd_x    = SCREEN_CORDW'(w_rnd_full);

  // State register
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) r_state <= S_SCAN;
    else     r_state <= w_state_nxt;
  end

  // Next-state: a pass starts only on an enabled frame and always runs to the end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SCAN:  if (bus.frame && bus.en) w_state_nxt = S_MOVE;
      S_MOVE:  if (w_last) w_state_nxt = S_SCAN;
      default: w_state_nxt = S_SCAN;
    endcase
  end

  // Obstacle index walks 0..N_OBJ-1 during a pass, parked at 0 otherwise
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst)                             r_idx <= '0;
    else if (r_state == S_MOVE && !w_last) r_idx <= r_idx + 1'b1;
    else                                 r_idx <= '0;
  end

  // Popcount of the closing frame's hits and saturating add
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_OBJ; i++) w_pop = w_pop + c_SUMW'(w_acc_cur[i]);
    w_sum           = c_SUMW'(r_hit_count) + w_pop;
    w_hit_count_nxt = (w_sum > c_CNT_MAX) ? {HIT_CNTW{1'b1}} : w_sum[HIT_CNTW-1:0];
  end

  // Overlap accumulation while scanning; commit to hit status on frame
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_hit_mask  <= '0;
      r_collision <= 1'b0;
      r_hit_count <= '0;
    end else if (r_state == S_SCAN) begin
      if (bus.frame) begin
        r_hit_mask  <= w_acc_cur;
        r_collision <= |w_acc_cur;
        r_hit_count <= w_hit_count_nxt;
        r_acc       <= '0;
      end else begin
        r_acc       <= w_acc_cur;
      end
    end
  end

  // Galois LFSR advances once per obstacle update so each gets a fresh x
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst)                    r_lfsr <= LFSR_SEED;
    else if (r_state == S_MOVE) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);
  end

  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_obj
    localparam logic [SCREEN_CORDW-1:0] c_X0 = SCREEN_CORDW'(gi * (H_RES / N_OBJ));

    logic [SCREEN_CORDW-1:0] r_x;
    logic [SCREEN_CORDW-1:0] r_y;
    logic [c_W1-1:0]         w_x_sum;
    logic [c_W1-1:0]         w_y_sum;
    logic                    w_sel;

    assign w_sel   = (r_state == S_MOVE) && (r_idx == c_IDXW'(gi));
    assign w_x_sum = {1'b0, r_x} + c_W1'(DX);
    assign w_y_sum = {1'b0, r_y} + c_W1'(DY);

    // Move, wrap or respawn this obstacle on its slot of the pass
    always_ff @(posedge clk_pix or posedge rst) begin
      if (rst) begin
        r_x <= c_X0;
        r_y <= '0;
      end else if (w_sel) begin
        if (r_hit_mask[gi] || (w_y_sum >= c_VRES)) begin
          r_x <= w_rnd_x;
          r_y <= '0;
        end else begin
          r_y <= w_y_sum[SCREEN_CORDW-1:0];
          r_x <= (w_x_sum >= c_XLIM) ? '0 : w_x_sum[SCREEN_CORDW-1:0];
        end
      end
    end

    assign w_obj_x[gi*SCREEN_CORDW +: SCREEN_CORDW] = r_x;
    assign w_obj_y[gi*SCREEN_CORDW +: SCREEN_CORDW] = r_y;
  end

  assign bus.obj_x     = w_obj_x;
  assign bus.obj_y     = w_obj_y;
  assign bus.hit_mask  = r_hit_mask;
  assign bus.collision = r_collision;
  assign bus.hit_count = r_hit_count;
  assign bus.busy      = (r_state == S_MOVE);

endmodule
`default_nettype wire

// File: tb/tb_asteroid_field_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_asteroid_field_ctrl                                           |
// | Brief    : Scoreboard bench: stimulus pushes expected field state, monitor  |
// |            pops on end of pass (busy falling) or on an explicit sample.     |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_asteroid_field_ctrl;
  localparam int N  = 10;
  localparam int CW = 16;
  localparam int HC = 8;

  typedef struct packed {
    logic [N*CW-1:0] x;
    logic [N*CW-1:0] y;
    logic [N-1:0]    mask;
    logic            coll;
    logic [HC-1:0]   cnt;
    logic            busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  asteroid_field_if #(.N_OBJ(N), .SCREEN_CORDW(CW), .HIT_CNTW(HC)) bus ();

  asteroid_field_ctrl #(
    .N_OBJ(N), .SCREEN_CORDW(CW), .H_RES(640), .V_RES(480), .OBJ_W(40),
    .DX(1), .DY(3), .LFSR_SEED(16'hACE1), .HIT_CNTW(HC)
  ) dut (
    .clk_pix(clk),
    .rst    (rst),
    .bus    (bus)
  );

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        chk_req = 1'b0;

  // Reference model state
  int          mx[N];
  int          my[N];
  logic [15:0] mlfsr;
  int          mcnt;
  logic [N-1:0] mmask;
  logic [N-1:0] tb_acc;

  task automatic cmp(input string name, input logic [N*CW-1:0] act, input logic [N*CW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.x[i*CW +: CW] = CW'(mx[i]);
      e.y[i*CW +: CW] = CW'(my[i]);
    end
    e.mask = mmask;
    e.coll = |mmask;
    e.cnt  = HC'(mcnt);
    e.busy = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = i * 64;
      my[i] = 0;
    end
    mlfsr  = 16'hACE1;
    mcnt   = 0;
    mmask  = '0;
    tb_acc = '0;
  endtask

  task automatic model_commit(input logic en_v, input logic [N-1:0] acc_all);
    int rnd;
    mmask = acc_all;
    mcnt  = mcnt + $countones(acc_all);
    if (mcnt > 255) mcnt = 255;
    if (en_v) begin
      for (int i = 0; i < N; i++) begin
        rnd = int'(mlfsr) % 600;
        if (mmask[i] || (my[i] + 3 >= 480)) begin
          mx[i] = rnd;
          my[i] = 0;
        end else begin
          my[i] = my[i] + 3;
          mx[i] = (mx[i] + 1 >= 600) ? 0 : mx[i] + 1;
        end
        mlfsr = {1'b0, mlfsr[15:1]} ^ (mlfsr[0] ? 16'hB400 : 16'h0000);
      end
    end
  endtask

  // Monitor: compare whenever the DUT completes a pass or a sample is requested
  exp_t e;
  int   bcnt = 0;
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    if (chk_req || (!rst && busy_q && !bus.busy)) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got busy_fall/sample expected none");
      end else begin
        e = q.pop_front();
        cmp("obj_x",     bus.obj_x,     e.x);
        cmp("obj_y",     bus.obj_y,     e.y);
        cmp("hit_mask",  N*CW'(bus.hit_mask),  N*CW'(e.mask));
        cmp("collision", N*CW'(bus.collision), N*CW'(e.coll));
        cmp("hit_count", N*CW'(bus.hit_count), N*CW'(e.cnt));
        cmp("busy",      N*CW'(bus.busy),      N*CW'(e.busy));
      end
      if (!chk_req) cmp("busy_cycles", N*CW'(bcnt), N*CW'(N));
    end
    if (rst)           bcnt = 0;
    else if (bus.busy) bcnt++;
    else               bcnt = 0;
    busy_q = bus.busy;
  end

  task automatic do_chk();
    q.push_back(snap());
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic ovl(input logic [N-1:0] m, input int n);
    @(posedge clk); #1;
    bus.ship_drawing = 1'b1;
    bus.obj_drawing  = m;
    repeat (n) @(posedge clk);
    #1;
    bus.ship_drawing = 1'b0;
    bus.obj_drawing  = '0;
    if (bus.en) tb_acc = tb_acc | m;
  endtask

  // One frame pulse; optional overlap in the frame cycle, en drop and a
  // stray frame pulse during the pass. skip_push: caller already queued.
  task automatic do_frame(input logic [N-1:0] ovl_same, input int drop_en,
                          input int mid_frame, input bit skip_push);
    logic en_v;
    en_v = bus.en;
    @(posedge clk); #1;
    bus.frame        = 1'b1;
    bus.ship_drawing = |ovl_same;
    bus.obj_drawing  = ovl_same;
    model_commit(en_v, tb_acc | (en_v ? ovl_same : '0));
    tb_acc = '0;
    if (en_v && !skip_push) q.push_back(snap());
    @(posedge clk); #1;
    bus.frame        = 1'b0;
    bus.ship_drawing = 1'b0;
    bus.obj_drawing  = '0;
    for (int k = 0; k < N + 2; k++) begin
      @(posedge clk); #1;
      if (k == drop_en) bus.en = 1'b0;
      bus.frame = (k == mid_frame);
    end
    bus.frame = 1'b0;
    if (!en_v) do_chk();
  endtask

  initial begin
    exp_t h;
    bus.en = 1'b0; bus.frame = 1'b0; bus.ship_drawing = 1'b0; bus.obj_drawing = '0;
    model_reset();

    // Reset state, hand values
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      h.x[i*CW +: CW] = CW'(i * 64);
      h.y[i*CW +: CW] = '0;
    end
    h.mask = '0; h.coll = 1'b0; h.cnt = '0; h.busy = 1'b0;
    q.push_back(h);
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
    rst = 1'b0;

    // First pass, hand values: y=3, x=i*64+1
    bus.en = 1'b1;
    for (int i = 0; i < N; i++) begin
      h.x[i*CW +: CW] = CW'(i * 64 + 1);
      h.y[i*CW +: CW] = CW'(3);
    end
    q.push_back(h);
    do_frame('0, -1, -1, 1'b1);

    // Overlap on obstacle 2 for 5 cycles, then overlap only in the frame cycle
    ovl(10'h004, 5);
    do_frame('0, -1, -1, 1'b0);
    do_frame(10'h010, -1, -1, 1'b0);

    // Long run: bottom-edge respawn and right-edge x wrap
    for (int f = 0; f < 165; f++) do_frame('0, -1, -1, 1'b0);

    // Disabled field: overlaps ignored, positions frozen, hit_mask cleared
    bus.en = 1'b0;
    ovl(10'h3FF, 3);
    for (int f = 0; f < 3; f++) do_frame('0, -1, -1, 1'b0);

    // en dropped mid-pass completes the pass, then nothing moves
    bus.en = 1'b1;
    do_frame('0, 3, -1, 1'b0);
    do_frame('0, -1, -1, 1'b0);

    // Frame pulse during a pass is ignored
    bus.en = 1'b1;
    do_frame('0, -1, 2, 1'b0);
    do_chk();

    // Saturation of hit_count
    for (int f = 0; f < 27; f++) begin
      ovl(10'h3FF, 2);
      do_frame('0, -1, -1, 1'b0);
    end

    // Asynchronous reset in the middle of a pass at idx 4
    @(posedge clk); #1;
    bus.frame = 1'b1;
    @(posedge clk); #1;
    bus.frame = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    do_chk();
    rst = 1'b0;

    // Recovery after reset
    do_frame('0, -1, -1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    cmp("queue_empty", N*CW'(q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
